fp32_addsub_seq: RTL and testbench
==================================

# fp32_addsub_seq

Hardware initiator for the fp32 add/sub unit (`fp32_adder_sub` or `fp32_adder_sub_comb`).
- Accepts operand pairs from upstream on a valid/ready stream and issues each pair twice to the adder: add (op=0), then subtract (op=1).
- Drives single-cycle `valid_in` pulses, waits for `valid_out`, and returns each result downstream with its opcode.
- Sits between a data source (sample buffer or wavelet stage) and the adder, replacing the simulation-only stimulus loop in hardware.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before a result is declared lost; range 2..1023.
- `DO_SUB`, 1: 1 = issue add then sub per pair; 0 = add only.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  upstream operand pair valid.
- `s_ready`  out  1  block can accept a pair.
- `s_a`  in  32  operand A, IEEE-754 single.
- `s_b`  in  32  operand B.
- `add_dina`  out  32  to adder `dina`.
- `add_dinb`  out  32  to adder `dinb`.
- `add_op`  out  1  to adder `op`; 0 add, 1 sub.
- `add_valid_in`  out  1  to adder `valid_in`; one-cycle pulse.
- `add_valid_out`  in  1  from adder `valid_out`; may stay high several cycles.
- `add_result`  in  32  from adder `result`.
- `m_valid`  out  1  result valid downstream.
- `m_ready`  in  1  downstream accepts.
- `m_result`  out  32  captured result, or qNaN 32'h7FC00000 on timeout.
- `m_op`  out  1  opcode that produced `m_result`.
- `m_timeout`  out  1  qualifies `m_valid`: result was synthesised by timeout.
- `err_stray`  out  1  sticky; set when `add_valid_out` rises outside WAIT.

## Operation
FSM states and transitions:
- **IDLE**: `s_ready`=1. On `s_valid&&s_ready`, latch `s_a`/`s_b`, set op=0, go to ISSUE.
- **ISSUE**: if `add_valid_out`=1 (previous result still held high), stall here with `add_valid_in`=0. Otherwise assert `add_valid_in` for exactly this cycle, with `add_dina`/`add_dinb`/`add_op` stable, clear the timer, and go to WAIT.
- **WAIT**: on the first cycle with `add_valid_out`=1, register `add_result` into `m_result`, set `m_timeout`=0, and go to OUT. If the timer reaches `TIMEOUT_CYCLES` with no `valid_out`, load `m_result`=7FC00000 and `m_timeout`=1, then go to OUT.
- **OUT**: `m_valid`=1 and all m-outputs hold until `m_ready`. On handshake:
  - if op=0 and `DO_SUB`=1: set op=1, go to ISSUE;
  - otherwise go to IDLE.

Rules:
- `add_dina`/`add_dinb` hold the latched pair from ISSUE until the next accept; `add_op` holds until the next ISSUE.
- Stray detection: a rising edge of `add_valid_out` seen in IDLE, ISSUE or OUT sets `err_stray`. Only `rst` clears it. Stray results are never forwarded. A late result arriving after a timeout is therefore flagged, not emitted.
- Timer width is clog2(`TIMEOUT_CYCLES`+1). It saturates and does not wrap.

## Timing
- Reset values:
  - state IDLE; `s_ready`=0 (registered, rises on the first clock after `rst` deasserts);
  - `add_valid_in`=0, `add_op`=0, `add_dina`=`add_dinb`=0;
  - `m_valid`=0, `m_result`=0, `m_op`=0, `m_timeout`=0, `err_stray`=0.
- Accept at edge N → `add_valid_in` high in cycle N+1 → WAIT from N+2.
- `add_valid_out` first seen in cycle K → `m_valid` high in K+1.
- `m_ready` high while `m_valid` high → next `add_valid_in` in the following cycle (one ISSUE cycle), unless stalled by a held `add_valid_out`.
- A pair costs 2×(adder latency + 2) + 1 cycles minimum with `DO_SUB`=1 and no backpressure.
- `s_ready` is 0 from the accept until the final OUT handshake. No second pair is buffered.
- An `add_valid_out` arriving in the same cycle as the timer reaching its limit counts as a real result, not a timeout.
- `rst` mid-operation: all outputs return to reset values immediately and the pending pair is discarded. The adder must be reset together with this block.

## Structure
- Shared header `fp32_defs.vh`:
  - `FP32_QNAN` = 32'h7FC00000;
  - `FP32_OP_ADD` = 0, `FP32_OP_SUB` = 1;
  - FSM state encodings IDLE/ISSUE/WAIT/OUT (2-bit).
- One sub-module, `fp32_wait_timer`: saturating counter with clear, enable and `expired` output, parameterised by `TIMEOUT_CYCLES`.
- The adder itself is instantiated outside this block.

## Test plan
1. **Basic pair.** `s_a`=3F800000, `s_b`=40000000 into a registered adder.
   Required: `m_result`=40400000 with `m_op`=0, then BF800000 with `m_op`=1; exactly two `add_valid_in` pulses, each one cycle wide.
2. **Backpressure.** Hold `m_ready`=0 for 10 cycles in OUT.
   Required: `m_result`/`m_op` stable; no further `add_valid_in`; `s_ready`=0 throughout.
3. **Timeout.** Adder model never raises `valid_out`, `TIMEOUT_CYCLES`=8.
   Required: `m_valid` with 7FC00000, `m_timeout`=1, 9–10 cycles after `add_valid_in`. A `valid_out` injected later sets `err_stray`=1 and produces no extra `m_valid`.
4. **Held valid_out.** Adder holds `valid_out` high for 3 cycles.
   Required: one result captured; the sub ISSUE stalls until `valid_out` falls; no `err_stray`.
5. **Reset mid-WAIT.** Assert `rst` in WAIT.
   Required: all outputs at reset values in the same cycle; after release `s_ready`=1 one clock later; the next pair 40A00000, 3F800000 yields 40C00000 then 40800000.
6. **Add only.** `DO_SUB`=0, three back-to-back pairs.
   Required: exactly three results, all `m_op`=0, and `s_ready` reasserted after each OUT handshake.

Source files
------------

// File: rtl/fp32_addsub_seq_pkg.sv
// Shared constants and types for the fp32 add/sub sequencer and its wait timer.
package fp32_addsub_seq_pkg;

  localparam int unsigned FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_QNAN   = 32'h7FC0_0000;
  localparam logic              FP32_OP_ADD = 1'b0;
  localparam logic              FP32_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [FP32_W-1:0] a;
    logic [FP32_W-1:0] b;
  } fp32_pair_t;

  typedef struct packed {
    logic [FP32_W-1:0] result;
    logic              op;
    logic              timeout;
  } seq_resp_t;

  // Counter width able to hold the value 'limit' itself.
  function automatic int unsigned timer_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fp32_addsub_seq_wait_timer.sv
// Saturating wait counter: clear has priority over enable; expired_o is high
// while the count sits at TIMEOUT_CYCLES.
module fp32_addsub_seq_wait_timer
  import fp32_addsub_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned   CW    = timer_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fp32_addsub_seq.sv
// Issues each accepted operand pair to an external fp32 adder as add, then
// optionally sub, and returns every result downstream tagged with its opcode.
module fp32_addsub_seq
  import fp32_addsub_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          DO_SUB         = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FP32_W-1:0] s_a,
  input  logic [FP32_W-1:0] s_b,
  output logic [FP32_W-1:0] add_dina,
  output logic [FP32_W-1:0] add_dinb,
  output logic              add_op,
  output logic              add_valid_in,
  input  logic              add_valid_out,
  input  logic [FP32_W-1:0] add_result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FP32_W-1:0] m_result,
  output logic              m_op,
  output logic              m_timeout,
  output logic              err_stray
);

  seq_state_e state_q;
  fp32_pair_t pair_q;
  seq_resp_t  resp_q;
  logic       op_q;
  logic       vin_q;
  logic       s_ready_q;
  logic       m_valid_q;
  logic       stray_q;
  logic       vout_q;
  logic       timer_expired;
  logic       vout_rise;

  fp32_addsub_seq_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_ISSUE),
    .en_i     (state_q == ST_WAIT),
    .expired_o(timer_expired)
  );

  assign vout_rise = add_valid_out && !vout_q;

  // add_valid_in is registered, so entering ISSUE pre-decides the pulse from
  // the current valid_out; a held valid_out keeps ISSUE stalled until it drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pair_q    <= '0;
      resp_q    <= '0;
      op_q      <= FP32_OP_ADD;
      vin_q     <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      stray_q   <= 1'b0;
      vout_q    <= 1'b0;
    end else begin
      vin_q  <= 1'b0;
      vout_q <= add_valid_out;
      if (vout_rise && (state_q != ST_WAIT)) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (s_valid && s_ready_q) begin
            pair_q    <= '{a: s_a, b: s_b};
            op_q      <= FP32_OP_ADD;
            s_ready_q <= 1'b0;
            vin_q     <= !add_valid_out;
            state_q   <= ST_ISSUE;
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (vin_q) begin
            state_q <= ST_WAIT;
          end else if (!add_valid_out) begin
            vin_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A result coinciding with expiry wins over the timeout.
          if (add_valid_out) begin
            resp_q    <= '{result: add_result, op: op_q, timeout: 1'b0};
            m_valid_q <= 1'b1;
            state_q   <= ST_OUT;
          end else if (timer_expired) begin
            resp_q    <= '{result: FP32_QNAN, op: op_q, timeout: 1'b1};
            m_valid_q <= 1'b1;
            state_q   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (DO_SUB && (op_q == FP32_OP_ADD)) begin
              op_q    <= FP32_OP_SUB;
              vin_q   <= !add_valid_out;
              state_q <= ST_ISSUE;
            end else begin
              s_ready_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign add_dina     = pair_q.a;
  assign add_dinb     = pair_q.b;
  assign add_op       = op_q;
  assign add_valid_in = vin_q;
  assign m_valid      = m_valid_q;
  assign m_result     = resp_q.result;
  assign m_op         = resp_q.op;
  assign m_timeout    = resp_q.timeout;
  assign err_stray    = stray_q;

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Scoreboard bench for fp32_addsub_seq with a behavioural integer-valued fp32 adder.
module tb_fp32_addsub_seq;

  localparam int unsigned TO   = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] r;
    logic        op;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main DUT (DO_SUB=1)
  logic        s_valid, s_ready, add_op, add_valid_in, add_valid_out;
  logic [31:0] s_a, s_b, add_dina, add_dinb, add_result, m_result;
  logic        m_valid, m_ready, m_op, m_timeout, err_stray;
  // add-only DUT
  logic        ao_s_valid, ao_s_ready, ao_op, ao_vin, ao_vout;
  logic [31:0] ao_s_a, ao_s_b, ao_dina, ao_dinb, ao_res, ao_m_result;
  logic        ao_m_valid, ao_m_ready, ao_m_op, ao_m_timeout, ao_err;

  fp32_addsub_seq #(.TIMEOUT_CYCLES(TO), .DO_SUB(1'b1)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .add_dina(add_dina), .add_dinb(add_dinb), .add_op(add_op), .add_valid_in(add_valid_in),
    .add_valid_out(add_valid_out), .add_result(add_result), .m_valid(m_valid),
    .m_ready(m_ready), .m_result(m_result), .m_op(m_op), .m_timeout(m_timeout),
    .err_stray(err_stray));

  fp32_addsub_seq #(.TIMEOUT_CYCLES(TO), .DO_SUB(1'b0)) u_dut_ao (
    .clk(clk), .rst(rst), .s_valid(ao_s_valid), .s_ready(ao_s_ready), .s_a(ao_s_a), .s_b(ao_s_b),
    .add_dina(ao_dina), .add_dinb(ao_dinb), .add_op(ao_op), .add_valid_in(ao_vin),
    .add_valid_out(ao_vout), .add_result(ao_res), .m_valid(ao_m_valid),
    .m_ready(ao_m_ready), .m_result(ao_m_result), .m_op(ao_m_op), .m_timeout(ao_m_timeout),
    .err_stray(ao_err));

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   vin_cnt = 0;
  logic vin_prev = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] ao_q[$];
  int   ao_seen = 0;
  logic ao_chk_rdy = 1'b0;

  // Adder model controls
  logic        mdl_vout = 1'b0, inj_vout = 1'b0, mute = 1'b0;
  logic [31:0] mdl_r;
  int          lat_cfg = 1, hold_cfg = 1, mdl_lat, mdl_hold;
  logic        bp_hold = 1'b0, rnd_ready = 1'b0;
  logic        ao_v;
  logic [31:0] ao_r;

  assign add_valid_out = mdl_vout | inj_vout;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact fp32 encode/decode for integers with magnitude below 2^24.
  function automatic logic [31:0] i2f(input int v);
    int mag, p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if ((mag >> i) != 0) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e, m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({8'd0, 1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_ev(input string name, input string got, input string req);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %s, required %s", name, got, req);
  endtask

  task automatic push_pair(input int a, input int b);
    exp_q.push_back('{r: i2f(a + b), op: 1'b0, tmo: 1'b0});
    exp_q.push_back('{r: i2f(a - b), op: 1'b1, tmo: 1'b0});
  endtask

  // Main adder model: result after lat cycles, valid_out held hold cycles.
  initial begin
    mdl_r = 32'h0;
    forever begin
      @(negedge clk);
      if (add_valid_in && !mute && !rst) begin
        ao_r     = 32'h0;
        mdl_lat  = (lat_cfg == 0) ? int'($urandom_range(4, 1)) : lat_cfg;
        mdl_hold = (hold_cfg == 0) ? int'($urandom_range(2, 1)) : hold_cfg;
        mdl_r    = i2f(add_op ? f2i(add_dina) - f2i(add_dinb) : f2i(add_dina) + f2i(add_dinb));
        @(posedge clk);
        repeat (mdl_lat - 1) @(posedge clk);
        #1 mdl_vout = 1'b1;
        repeat (mdl_hold) @(posedge clk);
        #1 mdl_vout = 1'b0;
      end
    end
  end
  assign add_result = mdl_r;

  // Add-only adder model: fixed one-cycle latency.
  initial begin
    ao_vout = 1'b0;
    ao_res  = 32'h0;
    forever begin
      @(negedge clk);
      ao_v = ao_vin;
      ao_r = i2f(ao_op ? f2i(ao_dina) - f2i(ao_dinb) : f2i(ao_dina) + f2i(ao_dinb));
      @(posedge clk);
      #1 ao_vout = ao_v;
      if (ao_v) ao_res = ao_r;
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_ready = bp_hold ? 1'b0 : (rnd_ready ? ($urandom_range(9) < 7) : 1'b1);
    end
  end

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        fail_ev("unexpected_m_valid", "m_valid with no pending result", "no m_valid");
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_result", m_result, mon_e.r);
        chk("m_op", 32'(m_op), 32'(mon_e.op));
        chk("m_timeout", 32'(m_timeout), 32'(mon_e.tmo));
      end
    end
  end

  // add_valid_in must be a single-cycle pulse and never overlap valid_out.
  always @(negedge clk) begin
    if (add_valid_in) begin
      chk("vin_width", 32'(vin_prev), 32'd0);
      chk("vin_while_vout", 32'(add_valid_out), 32'd0);
      if (!vin_prev) vin_cnt <= vin_cnt + 1;
    end
    vin_prev <= add_valid_in;
  end

  // Monitor for the add-only DUT.
  always @(negedge clk) begin
    if (ao_chk_rdy) begin
      chk("ao_s_ready_after_out", 32'(ao_s_ready), 32'd1);
      ao_chk_rdy <= 1'b0;
    end
    if (!rst && ao_m_valid) begin
      if (ao_q.size() == 0) begin
        fail_ev("ao_unexpected_m_valid", "extra result", "no m_valid");
      end else begin
        chk("ao_m_result", ao_m_result, ao_q.pop_front());
        chk("ao_m_op", 32'(ao_m_op), 32'd0);
        chk("ao_m_timeout", 32'(ao_m_timeout), 32'd0);
      end
      ao_seen    <= ao_seen + 1;
      ao_chk_rdy <= 1'b1;
    end
  end

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    while (!s_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail_ev("accept_wait", "s_ready low", "s_ready high");
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(s_ready && exp_q.size() == 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!(s_ready && exp_q.size() == 0)) fail_ev("drain_wait", "results still pending", "all results");
  endtask

  task automatic wait_vin();
    int n;
    n = 0;
    @(negedge clk);
    while (!add_valid_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!add_valid_in) fail_ev("vin_wait", "no add_valid_in", "add_valid_in pulse");
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) fail_ev("m_valid_wait", "no m_valid", "m_valid");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_add_valid_in"}, 32'(add_valid_in), 32'd0);
    chk({tag, "_add_op"}, 32'(add_op), 32'd0);
    chk({tag, "_add_dina"}, add_dina, 32'd0);
    chk({tag, "_add_dinb"}, add_dinb, 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_result"}, m_result, 32'd0);
    chk({tag, "_m_op"}, 32'(m_op), 32'd0);
    chk({tag, "_m_timeout"}, 32'(m_timeout), 32'd0);
    chk({tag, "_err_stray"}, 32'(err_stray), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a, b, v0, t0, d;
    logic [31:0] r0;
    logic        o0;
    s_valid = 1'b0; s_a = 32'h0; s_b = 32'h0;
    ao_s_valid = 1'b0; ao_s_a = 32'h0; ao_s_b = 32'h0; ao_m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1 chk("s_ready_at_release", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("s_ready_after_release", 32'(s_ready), 32'd1);

    // Basic pair through a registered adder.
    v0 = vin_cnt;
    exp_q.push_back('{r: 32'h4040_0000, op: 1'b0, tmo: 1'b0});
    exp_q.push_back('{r: 32'hBF80_0000, op: 1'b1, tmo: 1'b0});
    send_pair(32'h3F80_0000, 32'h4000_0000);
    wait_drain();
    chk("basic_vin_pulses", 32'(vin_cnt - v0), 32'd2);

    // Backpressure in OUT for 10 cycles.
    bp_hold = 1'b1;
    push_pair(7, -3);
    send_pair(i2f(7), i2f(-3));
    wait_mvalid();
    r0 = m_result;
    o0 = m_op;
    chk("bp_first_result", r0, i2f(4));
    repeat (10) begin
      @(negedge clk);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_result", m_result, r0);
      chk("bp_m_op", 32'(m_op), 32'(o0));
      chk("bp_no_vin", 32'(add_valid_in), 32'd0);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
    end
    bp_hold = 1'b0;
    wait_drain();

    // Adder holding valid_out for 3 cycles.
    hold_cfg = 3;
    push_pair(10, 4);
    send_pair(i2f(10), i2f(4));
    wait_drain();
    chk("held_no_stray", 32'(err_stray), 32'd0);

    // Randomized pairs, random latency/hold and downstream readiness.
    rnd_ready = 1'b1; lat_cfg = 0; hold_cfg = 0;
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(2000)) - 1000;
      b = int'($urandom_range(2000)) - 1000;
      push_pair(a, b);
      send_pair(i2f(a), i2f(b));
    end
    wait_drain();

    // Result landing exactly on the timer limit is a real result.
    rnd_ready = 1'b0; lat_cfg = int'(TO) + 1; hold_cfg = 1;
    push_pair(9, 2);
    send_pair(i2f(9), i2f(2));
    wait_drain();
    chk("limit_no_stray", 32'(err_stray), 32'd0);
    lat_cfg = 1;

    // Timeout: adder never answers.
    mute = 1'b1;
    exp_q.push_back('{r: QNAN, op: 1'b0, tmo: 1'b1});
    exp_q.push_back('{r: QNAN, op: 1'b1, tmo: 1'b1});
    send_pair(i2f(1), i2f(1));
    wait_vin();
    t0 = cyc;
    wait_mvalid();
    d = cyc - t0;
    if (d < 9 || d > 10) fail_ev("timeout_latency", $sformatf("%0d cycles", d), "9..10 cycles");
    else chk("timeout_latency", 32'(d), 32'(d));
    wait_drain();
    @(negedge clk) inj_vout = 1'b1;
    @(negedge clk) inj_vout = 1'b0;
    chk("stray_flag", 32'(err_stray), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stray_not_forwarded", 32'(m_valid), 32'd0);
    end

    // Reset in WAIT, then a clean pair.
    send_pair(i2f(2), i2f(3));
    wait_vin();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk_reset_outputs("midwait_reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("s_ready_at_release2", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("s_ready_after_release2", 32'(s_ready), 32'd1);
    mute = 1'b0;
    exp_q.push_back('{r: 32'h40C0_0000, op: 1'b0, tmo: 1'b0});
    exp_q.push_back('{r: 32'h4080_0000, op: 1'b1, tmo: 1'b0});
    send_pair(32'h40A0_0000, 32'h3F80_0000);
    wait_drain();

    rnd_ready = 1'b1; lat_cfg = 0; hold_cfg = 0;
    for (int i = 0; i < 15; i++) begin
      a = int'($urandom_range(2000)) - 1000;
      b = int'($urandom_range(2000)) - 1000;
      push_pair(a, b);
      send_pair(i2f(a), i2f(b));
    end
    wait_drain();
    chk("final_no_stray", 32'(err_stray), 32'd0);

    // Add-only instance: three back-to-back pairs.
    for (int i = 0; i < 3; i++) begin
      int n;
      a = int'($urandom_range(2000)) - 1000;
      b = int'($urandom_range(2000)) - 1000;
      ao_q.push_back(i2f(a + b));
      @(negedge clk);
      ao_s_a = i2f(a);
      ao_s_b = i2f(b);
      ao_s_valid = 1'b1;
      n = 0;
      while (!ao_s_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!ao_s_ready) fail_ev("ao_accept_wait", "s_ready low", "s_ready high");
      @(posedge clk);
      #1;
    end
    ao_s_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("ao_result_count", 32'(ao_seen), 32'd3);
    chk("ao_queue_empty", 32'(ao_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
